// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer geometry, bus widths and fill FSM states
package fb_pkg;

    localparam int H_RES   = 320;
    localparam int V_RES   = 240;
    localparam int ADDR_W  = 17;
    localparam int COLOR_W = 12;

    // Coordinate width wide enough that origin + size (9-bit + 9-bit) never overflows
    localparam int CRD_W   = 10;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        FILL,
        DONE
    } fill_state_t;

    function automatic logic [CRD_W-1:0] clip_end(
        input logic [CRD_W-1:0] org,
        input logic [CRD_W-1:0] len,
        input logic [CRD_W-1:0] lim
    );
        logic [CRD_W-1:0] e;
        e = org + len;
        return (e > lim) ? lim : e;
    endfunction

endpackage

// File: rtl/fb_rect_walker.sv
// rtl/fb_rect_walker.sv - raster x/y walker over a clipped rectangle with row-base accumulator
module fb_rect_walker #(
    parameter int H_RES  = fb_pkg::H_RES,
    parameter int ADDR_W = fb_pkg::ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     run,
    input  logic                     stall,
    input  logic [fb_pkg::CRD_W-1:0] x0,
    input  logic [fb_pkg::CRD_W-1:0] y0,
    input  logic [fb_pkg::CRD_W-1:0] x_end,
    input  logic [fb_pkg::CRD_W-1:0] y_end,
    output logic [fb_pkg::CRD_W-1:0] x,
    output logic [fb_pkg::CRD_W-1:0] y,
    output logic [ADDR_W-1:0]        row_base,
    output logic                     last
);

    import fb_pkg::*;

    logic [CRD_W-1:0] x_start;
    logic [CRD_W-1:0] x_lim;
    logic [CRD_W-1:0] y_lim;
    logic             step;
    logic             row_wrap;

    assign step     = run && !stall;
    assign row_wrap = (x + 1'b1) == x_lim;
    assign last     = row_wrap && ((y + 1'b1) == y_lim);

    // The only multiply happens on load; each row afterwards just adds H_RES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x        <= '0;
            y        <= '0;
            x_start  <= '0;
            x_lim    <= '0;
            y_lim    <= '0;
            row_base <= '0;
        end else if (load) begin
            x        <= x0;
            y        <= y0;
            x_start  <= x0;
            x_lim    <= x_end;
            y_lim    <= y_end;
            row_base <= ADDR_W'(y0) * ADDR_W'(H_RES);
        end else if (step) begin
            if (row_wrap) begin
                x        <= x_start;
                y        <= y + 1'b1;
                row_base <= row_base + ADDR_W'(H_RES);
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_fill_arb.sv
// rtl/fb_fill_arb.sv - rectangle fill engine sharing a framebuffer port with display scanout
module fb_fill_arb #(
    parameter int H_RES   = fb_pkg::H_RES,
    parameter int V_RES   = fb_pkg::V_RES,
    parameter int ADDR_W  = fb_pkg::ADDR_W,
    parameter int COLOR_W = fb_pkg::COLOR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               disp_req,
    input  logic [ADDR_W-1:0]  disp_addr,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [8:0]         cmd_x0,
    input  logic [7:0]         cmd_y0,
    input  logic [8:0]         cmd_w,
    input  logic [7:0]         cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [COLOR_W-1:0] mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               err
);

    import fb_pkg::*;

    fill_state_t        state_q;
    fill_state_t        state_d;

    logic [8:0]         x0_q;
    logic [7:0]         y0_q;
    logic [8:0]         w_q;
    logic [7:0]         h_q;
    logic [COLOR_W-1:0] color_q;
    logic               err_q;

    logic [CRD_W-1:0]   x_end;
    logic [CRD_W-1:0]   y_end;
    logic [CRD_W-1:0]   wx;
    logic [CRD_W-1:0]   wy;
    logic [ADDR_W-1:0]  row_base;
    logic               last;

    logic               accept;
    logic               zero_size;
    logic               off_screen;
    logic               fill_wr;

    assign accept     = cmd_valid && cmd_ready;
    assign x_end      = clip_end({1'b0, x0_q}, {1'b0, w_q}, CRD_W'(H_RES));
    assign y_end      = clip_end({2'b0, y0_q}, {2'b0, h_q}, CRD_W'(V_RES));
    assign zero_size  = (w_q == '0) || (h_q == '0);
    assign off_screen = ({1'b0, x0_q} >= CRD_W'(H_RES)) || ({2'b0, y0_q} >= CRD_W'(V_RES));
    // Display always wins the port; the walker stalls on the same signal.
    assign fill_wr    = (state_q == FILL) && !disp_req;

    fb_rect_walker #(
        .H_RES  (H_RES),
        .ADDR_W (ADDR_W)
    ) u_walker (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_q == SETUP),
        .run      (state_q == FILL),
        .stall    (disp_req),
        .x0       ({1'b0, x0_q}),
        .y0       ({2'b0, y0_q}),
        .x_end    (x_end),
        .y_end    (y_end),
        .x        (wx),
        .y        (wy),
        .row_base (row_base),
        .last     (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                x0_q    <= cmd_x0;
                y0_q    <= cmd_y0;
                w_q     <= cmd_w;
                h_q     <= cmd_h;
                color_q <= cmd_color;
            end
            if (state_q == SETUP) begin
                err_q <= off_screen;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (off_screen || zero_size) begin
                    state_d = DONE;
                end else begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (fill_wr && last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_addr  = disp_addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (fill_wr) begin
            mem_addr  = row_base + ADDR_W'(wx);
            mem_we    = 1'b1;
            mem_wdata = color_q;
        end
    end

    logic unused_wy;
    assign unused_wy = ^wy;

endmodule

// File: tb/tb_fb_fill_arb.sv
// tb/tb_fb_fill_arb.sv - randomized and directed self-checking bench for fb_fill_arb
module tb_fb_fill_arb;

    localparam int HR = 320;
    localparam int VR = 240;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        disp_req = 1'b0;
    logic [16:0] disp_addr = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [8:0]  cmd_x0 = '0;
    logic [7:0]  cmd_y0 = '0;
    logic [8:0]  cmd_w = '0;
    logic [7:0]  cmd_h = '0;
    logic [11:0] cmd_color = '0;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    fb_fill_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .disp_req  (disp_req),
        .disp_addr (disp_addr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode: 0 = display idle, 1 = display toggles 1,0,1,0..., 2 = random display traffic
    task automatic run_fill(input int x0, input int y0, input int w, input int h,
                            input int color, input int mode, input bit keep_valid,
                            input int nx0, input int ny0, input int nw, input int nh,
                            input int ncolor, input int abort_after);
        int  exp_q[$];
        bit  exp_err;
        bit  seen_done;
        int  idx;
        int  last_cyc;
        exp_err   = (x0 >= HR) || (y0 >= VR);
        seen_done = 1'b0;
        idx       = 0;
        last_cyc  = -1;
        if (!exp_err) begin
            for (int yy = y0; yy < y0 + h && yy < VR; yy++) begin
                for (int xx = x0; xx < x0 + w && xx < HR; xx++) begin
                    exp_q.push_back(yy * HR + xx);
                end
            end
        end

        @(negedge clk);
        disp_req  = 1'b0;
        cmd_valid = 1'b1;
        cmd_x0    = 9'(x0);
        cmd_y0    = 8'(y0);
        cmd_w     = 9'(w);
        cmd_h     = 8'(h);
        cmd_color = 12'(color);
        #1 chk("cmd_ready_idle", 32'(cmd_ready), 1);

        @(negedge clk);
        if (keep_valid) begin
            cmd_x0    = 9'(nx0);
            cmd_y0    = 8'(ny0);
            cmd_w     = 9'(nw);
            cmd_h     = 8'(nh);
            cmd_color = 12'(ncolor);
        end else begin
            cmd_valid = 1'b0;
            cmd_x0    = 9'($urandom);
            cmd_y0    = 8'($urandom);
            cmd_w     = 9'($urandom);
            cmd_h     = 8'($urandom);
            cmd_color = 12'($urandom);
        end
        #1;
        chk("setup_busy", 32'(busy), 1);
        chk("setup_ready", 32'(cmd_ready), 0);
        chk("setup_we", 32'(mem_we), 0);

        for (int cyc = 0; cyc < 4000 && !seen_done; cyc++) begin
            @(negedge clk);
            if (abort_after > 0 && idx == abort_after) begin
                disp_req = 1'b0;
                rst_n    = 1'b0;
                #1;
                chk("rst_we", 32'(mem_we), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_err", 32'(err), 0);
                repeat (3) begin
                    @(negedge clk);
                    #1 chk("rst_hold_we", 32'(mem_we), 0);
                end
                rst_n = 1'b1;
                #1;
                chk("rst_release_ready", 32'(cmd_ready), 1);
                chk("rst_release_busy", 32'(busy), 0);
                @(negedge clk);
                #1 chk("post_abort_done", 32'(done), 0);
                return;
            end
            if (mode == 0) disp_req = 1'b0;
            else if (mode == 1) disp_req = ((cyc % 2) == 0);
            else disp_req = 1'($urandom_range(0, 1));
            disp_addr = 17'($urandom_range(0, HR * VR - 1));
            #1;
            if (mem_we) begin
                chk("write_needs_idle_display", 32'(disp_req), 0);
                if (idx < exp_q.size()) begin
                    chk("write_addr", 32'(mem_addr), 32'(exp_q[idx]));
                    chk("write_data", 32'(mem_wdata), 32'(color));
                end else begin
                    chk("extra_write", 32'(idx), 32'(exp_q.size()));
                end
                idx++;
                last_cyc = cyc;
            end else begin
                chk("disp_passthru", 32'(mem_addr), 32'(disp_addr));
                chk("idle_wdata", 32'(mem_wdata), 0);
            end
            if (keep_valid) chk("ready_low_while_busy", 32'(cmd_ready), 0);
            if (done) begin
                seen_done = 1'b1;
                chk("write_count", 32'(idx), 32'(exp_q.size()));
                chk("err_flag", 32'(err), 32'(exp_err));
                chk("done_latency", 32'(cyc), 32'(last_cyc + 1));
            end else begin
                chk("err_without_done", 32'(err), 0);
            end
        end
        if (!seen_done) chk("done_timeout", 0, 1);

        if (!keep_valid) begin
            @(negedge clk);
            disp_req = 1'b0;
            #1;
            chk("after_done_ready", 32'(cmd_ready), 1);
            chk("after_done_busy", 32'(busy), 0);
            chk("after_done_pulse", 32'(done), 0);
        end
    endtask

    initial begin
        #2;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_err", 32'(err), 0);
        chk("reset_we", 32'(mem_we), 0);
        chk("reset_wdata", 32'(mem_wdata), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("reset_ready", 32'(cmd_ready), 1);

        run_fill(10, 5, 4, 2, 'hF00, 0, 1'b0, 0, 0, 0, 0, 0, 0);
        run_fill(10, 5, 4, 2, 'hF00, 1, 1'b0, 0, 0, 0, 0, 0, 0);
        run_fill(318, 238, 5, 5, 'h0F0, 0, 1'b0, 0, 0, 0, 0, 0, 0);
        run_fill(10, 10, 0, 3, 'h00F, 0, 1'b0, 0, 0, 0, 0, 0, 0);
        run_fill(320, 10, 4, 4, 'h0FF, 0, 1'b0, 0, 0, 0, 0, 0, 0);

        run_fill(20, 30, 3, 2, 'h0AB, 2, 1'b1, 40, 50, 2, 3, 'h123, 0);
        run_fill(40, 50, 2, 3, 'h123, 2, 1'b0, 0, 0, 0, 0, 0, 0);

        run_fill(100, 100, 4, 4, 'h555, 0, 1'b0, 0, 0, 0, 0, 0, 3);
        run_fill(7, 8, 3, 3, 'h777, 2, 1'b0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 10; n++) begin
            int rx0, ry0, rw, rh;
            rx0 = $urandom_range(0, 330);
            ry0 = $urandom_range(0, 245);
            rw  = $urandom_range(0, 12);
            rh  = $urandom_range(0, 6);
            run_fill(rx0, ry0, rw, rh, int'($urandom_range(0, 4095)), 2, 1'b0,
                     0, 0, 0, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fb_fill_arb.md
FB_FILL_ARB -- requirements
Module: fb_fill_arb

Interface
REQ-001 SHALL have parameters: H_RES, default 320, framebuffer width in pixels; V_RES, default 240, framebuffer height; ADDR_W, default 17, word-address width; COLOR_W, default 12, RGB444 pixel width.
REQ-002 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 disp_req  in  1  scanout needs the memory this cycle (high whenever not blanking).
REQ-005 disp_addr  in  ADDR_W  scanout read address, (y/2)*320 + x/2.
REQ-006 cmd_valid  in  1; cmd_ready  out  1; valid/ready fill-command handshake.
REQ-007 cmd_x0  in  9; cmd_y0  in  8; cmd_w  in  9; cmd_h  in  8; cmd_color  in  COLOR_W: rectangle origin, size and fill colour.
REQ-008 mem_addr  out  ADDR_W; mem_we  out  1; mem_wdata  out  COLOR_W: single-port framebuffer port.
REQ-009 busy  out  1  command in progress; done  out  1  one-cycle completion pulse; err  out  1  one-cycle pulse for a rejected command.

Function
REQ-010 SHALL implement FSM states IDLE, SETUP, FILL, DONE.
REQ-011 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a cycle with cmd_valid && cmd_ready, and all cmd_* fields SHALL be registered on that edge.
REQ-012 IDLE -> SETUP on accept; SETUP lasts exactly one cycle.
REQ-013 SETUP SHALL clip: x_end = min(x0+w, H_RES), y_end = min(y0+h, V_RES), computed at 10-bit width with no overflow.
REQ-014 SETUP -> DONE with no writes when w==0 or h==0; SETUP -> DONE with err pulse and no writes when x0>=H_RES or y0>=V_RES; otherwise SETUP -> FILL.
REQ-015 The row base SHALL be loaded in SETUP as y0*H_RES and advanced by +H_RES per row; no multiplier SHALL be used in FILL.
REQ-016 Arbitration SHALL be fixed priority to display: when disp_req=1, mem_addr=disp_addr and mem_we=0 in the same cycle (combinational mux), and the fill counters SHALL hold.
REQ-017 In FILL with disp_req=0: mem_addr = row_base + x, mem_we=1, mem_wdata=color; x SHALL increment, wrapping to x0 with y+1 when x+1==x_end.
REQ-018 The write of pixel (x_end-1, y_end-1) SHALL cause FILL -> DONE on the same edge.
REQ-019 DONE SHALL last one cycle, assert done=1 (and err when applicable), then go to IDLE; cmd_ready SHALL return to 1 in the following cycle.
REQ-020 busy SHALL be 1 in SETUP, FILL and DONE.
REQ-021 Outside FILL: mem_we=0, mem_addr=disp_addr and mem_wdata=0.
REQ-022 Writes in a W x H clipped fill SHALL total exactly W*H, in raster order, with no duplicates, regardless of disp_req pattern.

Reset
REQ-023 rst_n low SHALL, asynchronously: set state to IDLE, clear counters and registered command fields, and force busy=0, done=0, err=0 and mem_we=0; cmd_ready SHALL read 1 once rst_n is high.
REQ-024 Reset mid-FILL SHALL abort the command with no further writes and no done pulse.

Structure
REQ-025 H_RES, V_RES, ADDR_W, COLOR_W and the state enum SHALL live in shared package fb_pkg.
REQ-026 A single sub-module, fb_rect_walker (x/y counters, row base, last-pixel flag, with a stall input), SHALL be used; arbitration and FSM stay in the top.

Verification
REQ-027 Fill x0=10, y0=5, w=4, h=2, colour 0xF00, disp_req=0 -> 8 writes at addresses 1610..1613 and 1930..1933, data 0xF00; done pulses 1 cycle after the last write.
REQ-028 Same fill with disp_req toggling 1,0,1,0 -> writes occur only in disp_req=0 cycles; in disp_req=1 cycles mem_addr=disp_addr and mem_we=0; same 8 addresses in order.
REQ-029 x0=318, y0=238, w=5, h=5 -> clipped to 2x2, writes at 76478, 76479, 76798, 76799; no address > 76799.
REQ-030 w=0 -> no writes; done at the cycle after SETUP. x0=320 -> no writes; err=1 and done=1 together.
REQ-031 cmd_valid held high during a fill -> the second command is accepted only after done, on the first cycle with cmd_ready=1; fields changed mid-fill do not affect the active fill.
REQ-032 rst_n pulsed low after 3 writes of a 16-pixel fill -> mem_we=0 immediately, busy=0, no done; a new command then completes normally.
